soc_system_nios2_gen2_cpu_debug_cmd_bridge: RTL and testbench

//  Parametrised sysclk-side debug command bridge for the Nios II debug slave.
//  - Synchronises virtual-JTAG update strobes (vs_uir, vs_udr) into clk.
//  - Captures each IR/DR update into a command FIFO and presents commands on a valid/ready port.
//  - On each accepted command: updates jdo and pulses a per-channel take_action / take_no_action.
//  - Supersedes the fixed 2-bit-IR, 38-bit-DR, unbuffered sysclk decoder.

---
 rtl/soc_system_nios2_gen2_cpu_debug_cmd_bridge.sv | 171 +++++++++++++++++
 tb/tb_soc_system_nios2_gen2_cpu_debug_cmd_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_nios2_gen2_cpu_debug_cmd_bridge.sv
// rtl/soc_system_nios2_gen2_cpu_debug_cmd_bridge.sv - sysclk-side debug command bridge
//
// Purpose: brings virtual-JTAG update-IR / update-DR strobes into the system
// clock domain. Each DR update is queued with the IR value last captured. The
// consumer takes commands over a valid/ready port. Each accepted command
// updates jdo and fires a one-cycle per-channel take_action or take_no_action.
//
// Ports:
//   i_clk, i_reset_n            system clock, async active-low reset
//   i_ir_in, i_sr               tck-domain IR / shift register, stable around strobes
//   i_vs_uir, i_vs_udr          tck-domain update levels (asynchronous)
//   o_cmd_valid, i_cmd_ready    command head handshake
//   o_cmd_ir, o_cmd_data        command head contents
//   o_jdo                       DR of last accepted command
//   o_take_action/no_action     per-channel one-cycle pulses
//   o_fifo_level                entries held
//   o_overflow, o_bad_ir        sticky status, cleared by i_clear_status
module soc_system_nios2_gen2_cpu_debug_cmd_bridge #(
   parameter int IR_WIDTH    = 2,
   parameter int DR_WIDTH    = 38,
   parameter int NUM_CH      = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic [IR_WIDTH-1:0]           i_ir_in,
   input  logic [DR_WIDTH-1:0]           i_sr,
   input  logic                          i_vs_uir,
   input  logic                          i_vs_udr,
   output logic                          o_cmd_valid,
   input  logic                          i_cmd_ready,
   output logic [IR_WIDTH-1:0]           o_cmd_ir,
   output logic [DR_WIDTH-1:0]           o_cmd_data,
   output logic [DR_WIDTH-1:0]           o_jdo,
   output logic [NUM_CH-1:0]             o_take_action,
   output logic [NUM_CH-1:0]             o_take_no_action,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow,
   output logic                          o_bad_ir,
   input  logic                          i_clear_status
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = IR_WIDTH + DR_WIDTH;

   // Reset synchroniser: assertion is immediate, release lands on a clock edge.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_rst_sync <= 2'b00;
      else            r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // Strobe synchronisers and rising-edge detectors.
   logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync;
   logic                   r_uir_prev, r_udr_prev;
   logic                   w_uir_event, w_udr_event;

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_uir_sync <= '0;
         r_udr_sync <= '0;
         r_uir_prev <= 1'b0;
         r_udr_prev <= 1'b0;
      end else begin
         r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], i_vs_uir};
         r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], i_vs_udr};
         r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
         r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
      end
   end

   assign w_uir_event = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;
   assign w_udr_event = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;

   // Captured IR. A coincident DR push still sees the old value because the
   // push reads r_ir_q before this edge updates it.
   logic [IR_WIDTH-1:0] r_ir_q;

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n)         r_ir_q <= '0;
      else if (w_uir_event) r_ir_q <= i_ir_in;
   end

   // Command FIFO
   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_level;
   logic [EW-1:0] w_head;
   logic          w_pop, w_push_ok, w_drop, w_not_full;

   assign o_cmd_valid = (r_level != '0);
   assign w_head      = r_mem[r_rd_ptr];
   assign o_cmd_ir    = w_head[EW-1:DR_WIDTH];
   assign o_cmd_data  = w_head[DR_WIDTH-1:0];
   assign w_pop       = o_cmd_valid & i_cmd_ready;
   assign w_not_full  = (r_level != (AW+1)'(FIFO_DEPTH));
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_push_ok   = w_udr_event & (w_not_full | w_pop);
   assign w_drop      = w_udr_event & ~w_push_ok;

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_ir_q, i_sr};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_fifo_level = r_level;

   // Channel decode of the head IR; an IR with no matching channel is bad.
   logic [NUM_CH-1:0] w_ch_sel;
   logic              w_ir_ok;

   always_comb begin
      w_ch_sel = '0;
      for (int c = 0; c < NUM_CH; c++) w_ch_sel[c] = (o_cmd_ir == IR_WIDTH'(c));
   end

   assign w_ir_ok = |w_ch_sel;

   // Transfer side effects and sticky status.
   logic [DR_WIDTH-1:0] r_jdo;
   logic [NUM_CH-1:0]   r_take_action, r_take_no_action;
   logic                r_overflow, r_bad_ir;

   always_ff @(posedge i_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_jdo            <= '0;
         r_take_action    <= '0;
         r_take_no_action <= '0;
         r_overflow       <= 1'b0;
         r_bad_ir         <= 1'b0;
      end else begin
         r_take_action    <= '0;
         r_take_no_action <= '0;
         if (w_pop) begin
            r_jdo            <= o_cmd_data;
            r_take_action    <= w_ch_sel & {NUM_CH{o_cmd_data[DR_WIDTH-1]}};
            r_take_no_action <= w_ch_sel & {NUM_CH{~o_cmd_data[DR_WIDTH-1]}};
         end
         // Set has priority over a same-cycle clear.
         r_overflow <= w_drop | (r_overflow & ~i_clear_status);
         r_bad_ir   <= (w_pop & ~w_ir_ok) | (r_bad_ir & ~i_clear_status);
      end
   end

   assign o_jdo            = r_jdo;
   assign o_take_action    = r_take_action;
   assign o_take_no_action = r_take_no_action;
   assign o_overflow       = r_overflow;
   assign o_bad_ir         = r_bad_ir;

endmodule

// File: tb/tb_soc_system_nios2_gen2_cpu_debug_cmd_bridge.sv
// tb/tb_soc_system_nios2_gen2_cpu_debug_cmd_bridge.sv - bench for the debug command bridge
module tb_soc_system_nios2_gen2_cpu_debug_cmd_bridge;

   logic        clk, reset_n;
   logic [1:0]  ir_in;
   logic [37:0] sr;
   logic        vs_uir, vs_udr, cmd_ready, clear_status;

   logic        cmd_valid, overflow, bad_ir;
   logic [1:0]  cmd_ir;
   logic [37:0] cmd_data, jdo;
   logic [3:0]  take_action, take_no_action;
   logic [2:0]  fifo_level;

   logic        cmd_valid3, overflow3, bad_ir3;
   logic [1:0]  cmd_ir3;
   logic [37:0] cmd_data3, jdo3;
   logic [2:0]  take_action3, take_no_action3;
   logic [2:0]  fifo_level3;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   int pulse_cnt3 = 0;

   logic [39:0] model_q[$];
   logic [1:0]  model_ir;

   soc_system_nios2_gen2_cpu_debug_cmd_bridge dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_ir_in(ir_in), .i_sr(sr),
      .i_vs_uir(vs_uir), .i_vs_udr(vs_udr), .o_cmd_valid(cmd_valid),
      .i_cmd_ready(cmd_ready), .o_cmd_ir(cmd_ir), .o_cmd_data(cmd_data),
      .o_jdo(jdo), .o_take_action(take_action), .o_take_no_action(take_no_action),
      .o_fifo_level(fifo_level), .o_overflow(overflow), .o_bad_ir(bad_ir),
      .i_clear_status(clear_status));

   soc_system_nios2_gen2_cpu_debug_cmd_bridge #(.NUM_CH(3)) dut3 (
      .i_clk(clk), .i_reset_n(reset_n), .i_ir_in(ir_in), .i_sr(sr),
      .i_vs_uir(vs_uir), .i_vs_udr(vs_udr), .o_cmd_valid(cmd_valid3),
      .i_cmd_ready(cmd_ready), .o_cmd_ir(cmd_ir3), .o_cmd_data(cmd_data3),
      .o_jdo(jdo3), .o_take_action(take_action3), .o_take_no_action(take_no_action3),
      .o_fifo_level(fifo_level3), .o_overflow(overflow3), .o_bad_ir(bad_ir3),
      .i_clear_status(clear_status));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse monitor: count pulse cycles and require at most one active bit.
   always @(negedge clk) begin
      if ((take_action | take_no_action) != 4'b0) begin
         pulse_cnt++;
         checks++;
         if ($countones({take_action, take_no_action}) != 1) begin
            errors++;
            $display("FAIL onehot: take_action=%b take_no_action=%b required exactly one bit", take_action, take_no_action);
         end
      end
      if ((take_action3 | take_no_action3) != 3'b0) pulse_cnt3++;
   end

   // Expected {take_no_action, take_action} for a transfer of (ir, data), 4 channels.
   function automatic logic [7:0] exp_pulse(input logic [1:0] ir, input logic [37:0] d);
      logic [3:0] onehot;
      onehot = 4'b0001 << ir;
      return d[37] ? {4'b0000, onehot} : {onehot, 4'b0000};
   endfunction

   function automatic logic [37:0] rand_dr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[37:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_uir(input logic [1:0] ir);
      ir_in = ir;
      vs_uir = 1'b1;
      repeat (4) tick();
      vs_uir = 1'b0;
      repeat (4) tick();
      model_ir = ir;
   endtask

   // Push into the model only when it has room, mirroring the drop rule.
   task automatic do_udr(input logic [37:0] d);
      sr = d;
      vs_udr = 1'b1;
      repeat (4) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      if (model_q.size() < 4) model_q.push_back({model_ir, d});
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({cmd_valid, fifo_level, jdo, take_action, take_no_action, overflow, bad_ir} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b level=%0d jdo=%h ta=%b tna=%b ovf=%b bad=%b required all 0",
                  cmd_valid, fifo_level, jdo, take_action, take_no_action, overflow, bad_ir);
      end
      reset_n = 1'b1;
      repeat (5) tick();
      model_ir = 2'd0;
   endtask

   task automatic test_latency();
      cmd_ready = 1'b1;
      do_uir(2'd2);
      sr = {1'b1, 37'h5};
      vs_udr = 1'b1;
      tick(); tick();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++; $display("FAIL lat_edge2: cmd_valid=%b required 0", cmd_valid);
      end
      tick();
      checks++;
      if ({cmd_valid, cmd_ir, cmd_data} !== {1'b1, 2'd2, 38'h20_0000_0005}) begin
         errors++; $display("FAIL lat_edge3: valid=%b ir=%0d data=%h required 1/2/2000000005", cmd_valid, cmd_ir, cmd_data);
      end
      tick();
      checks++;
      if ({take_action, take_no_action, jdo} !== {4'b0100, 4'b0000, 38'h20_0000_0005}) begin
         errors++; $display("FAIL lat_pulse: ta=%b tna=%b jdo=%h required 0100/0000/2000000005", take_action, take_no_action, jdo);
      end
      tick();
      checks++;
      if ({take_action, take_no_action, cmd_valid} !== 9'b0) begin
         errors++; $display("FAIL lat_pulse_end: ta=%b tna=%b valid=%b required 0", take_action, take_no_action, cmd_valid);
      end
      vs_udr = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_overflow();
      logic [39:0] e;
      cmd_ready = 1'b0;
      do_uir(2'($urandom_range(0, 3)));
      for (int i = 0; i < 5; i++) do_udr(rand_dr());
      checks++;
      if ({fifo_level, overflow, cmd_valid} !== {3'd4, 1'b1, 1'b1}) begin
         errors++; $display("FAIL ovf_full: level=%0d ovf=%b valid=%b required 4/1/1", fifo_level, overflow, cmd_valid);
      end
      while (model_q.size() > 0) begin
         e = model_q.pop_front();
         checks++;
         if ({cmd_valid, cmd_ir, cmd_data} !== {1'b1, e}) begin
            errors++; $display("FAIL ovf_head: ir=%0d data=%h required %0d/%h", cmd_ir, cmd_data, e[39:38], e[37:0]);
         end
         cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
         checks++;
         if ({jdo, take_no_action, take_action} !== {e[37:0], exp_pulse(e[39:38], e[37:0])}) begin
            errors++; $display("FAIL ovf_xfer: jdo=%h tna=%b ta=%b required %h/%b", jdo, take_no_action, take_action, e[37:0], exp_pulse(e[39:38], e[37:0]));
         end
         tick();
      end
      checks++;
      if ({fifo_level, overflow} !== {3'd0, 1'b1}) begin
         errors++; $display("FAIL ovf_sticky: level=%0d ovf=%b required 0/1", fifo_level, overflow);
      end
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: ovf=%b required 0", overflow);
      end
   endtask

   task automatic test_full_pop();
      logic [39:0] e;
      logic [37:0] d5;
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_udr(rand_dr());
      d5 = rand_dr();
      sr = d5;
      vs_udr = 1'b1;
      tick(); tick();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      e = model_q.pop_front();
      model_q.push_back({model_ir, d5});
      checks++;
      if ({fifo_level, overflow, jdo} !== {3'd4, 1'b0, e[37:0]}) begin
         errors++; $display("FAIL fullpop: level=%0d ovf=%b jdo=%h required 4/0/%h", fifo_level, overflow, jdo, e[37:0]);
      end
      repeat (2) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      while (model_q.size() > 0) begin
         e = model_q.pop_front();
         checks++;
         if ({cmd_valid, cmd_ir, cmd_data} !== {1'b1, e}) begin
            errors++; $display("FAIL fullpop_head: ir=%0d data=%h required %0d/%h", cmd_ir, cmd_data, e[39:38], e[37:0]);
         end
         cmd_ready = 1'b1; tick(); cmd_ready = 1'b0; tick();
      end
      checks++;
      if ({fifo_level, overflow} !== 4'b0) begin
         errors++; $display("FAIL fullpop_end: level=%0d ovf=%b required 0/0", fifo_level, overflow);
      end
   endtask

   task automatic test_bad_ir();
      int p3;
      logic [37:0] d;
      cmd_ready = 1'b1;
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      do_uir(2'd3);
      d = rand_dr();
      d[37] = 1'b0;
      p3 = pulse_cnt3;
      do_udr(d);
      void'(model_q.pop_back());
      checks++;
      if ({bad_ir3, jdo3, fifo_level3} !== {1'b1, d, 3'd0} || pulse_cnt3 != p3) begin
         errors++; $display("FAIL bad_ir: bad=%b jdo=%h level=%0d pulses=%0d required 1/%h/0/%0d", bad_ir3, jdo3, fifo_level3, pulse_cnt3, d, p3);
      end
      checks++;
      if (bad_ir !== 1'b0) begin
         errors++; $display("FAIL bad_ir_4ch: bad=%b required 0", bad_ir);
      end
      clear_status = 1'b1; tick(); clear_status = 1'b0;
      checks++;
      if (bad_ir3 !== 1'b0) begin
         errors++; $display("FAIL bad_ir_clear: bad=%b required 0", bad_ir3);
      end
   endtask

   task automatic test_held_coincident();
      logic [39:0] e;
      logic [1:0]  a, b;
      logic [37:0] d1, d2;
      cmd_ready = 1'b0;
      a = 2'($urandom_range(0, 3));
      b = ~a;
      do_uir(a);
      d1 = rand_dr();
      sr = d1;
      vs_udr = 1'b1;
      repeat (20) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
      model_q.push_back({a, d1});
      checks++;
      if (fifo_level !== 3'd1) begin
         errors++; $display("FAIL held: level=%0d required 1", fifo_level);
      end
      d2 = rand_dr();
      ir_in = b; sr = d2;
      vs_uir = 1'b1; vs_udr = 1'b1;
      repeat (4) tick();
      vs_uir = 1'b0; vs_udr = 1'b0;
      repeat (4) tick();
      model_q.push_back({a, d2});
      model_ir = b;
      do_udr(rand_dr());
      checks++;
      if (fifo_level !== 3'd3) begin
         errors++; $display("FAIL coinc_level: level=%0d required 3", fifo_level);
      end
      while (model_q.size() > 0) begin
         e = model_q.pop_front();
         checks++;
         if ({cmd_valid, cmd_ir, cmd_data} !== {1'b1, e}) begin
            errors++; $display("FAIL coinc_head: ir=%0d data=%h required %0d/%h", cmd_ir, cmd_data, e[39:38], e[37:0]);
         end
         cmd_ready = 1'b1; tick(); cmd_ready = 1'b0; tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [39:0] e;
      int k;
      for (int r = 0; r < 5; r++) begin
         cmd_ready = 1'b0;
         k = $urandom_range(1, 4);
         for (int i = 0; i < k; i++) begin
            do_uir(2'($urandom_range(0, 3)));
            do_udr(rand_dr());
         end
         checks++;
         if (fifo_level !== 3'(k)) begin
            errors++; $display("FAIL b2b_level: level=%0d required %0d", fifo_level, k);
         end
         cmd_ready = 1'b1;
         for (int i = 0; i < k; i++) begin
            tick();
            e = model_q.pop_front();
            checks++;
            if ({jdo, take_no_action, take_action} !== {e[37:0], exp_pulse(e[39:38], e[37:0])}) begin
               errors++; $display("FAIL b2b_xfer: jdo=%h tna=%b ta=%b required %h/%b", jdo, take_no_action, take_action, e[37:0], exp_pulse(e[39:38], e[37:0]));
            end
         end
         cmd_ready = 1'b0;
         tick();
         checks++;
         if ({take_action, take_no_action, fifo_level} !== 11'b0) begin
            errors++; $display("FAIL b2b_idle: ta=%b tna=%b level=%0d required 0", take_action, take_no_action, fifo_level);
         end
      end
   endtask

   task automatic test_reset_mid();
      int p;
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) do_udr(rand_dr());
      checks++;
      if (fifo_level !== 3'd3) begin
         errors++; $display("FAIL rstmid_fill: level=%0d required 3", fifo_level);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({fifo_level, cmd_valid} !== 4'b0) begin
         errors++; $display("FAIL rstmid_clear: level=%0d valid=%b required 0/0", fifo_level, cmd_valid);
      end
      model_q.delete();
      tick(); tick();
      reset_n = 1'b1;
      p = pulse_cnt;
      cmd_ready = 1'b1;
      repeat (10) tick();
      checks++;
      if (pulse_cnt != p || cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
         errors++; $display("FAIL rstmid_quiet: pulses=%0d valid=%b level=%0d required %0d/0/0", pulse_cnt, cmd_valid, fifo_level, p);
      end
   endtask

   initial begin
      reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
      cmd_ready = 1'b0; clear_status = 1'b0; model_ir = '0;
      test_reset();
      test_latency();
      test_overflow();
      test_full_pop();
      test_bad_ir();
      test_held_coincident();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
